// File: rtl/reserv_station_pkg.sv
// Shared constants for the reservation station: default widths, the empty-tag
// encoding and the operation encodings.
package reserv_station_pkg;

  localparam int DATA_W_DEF = 17;
  localparam int TAG_W_DEF  = 3;

  // Producer tag meaning "operand value already present"
  localparam int TAG_NONE = 0;

  localparam logic OP_ADDMUL = 1'b1;
  localparam logic OP_SUBDIV = 1'b0;

endpackage : reserv_station_pkg

// File: rtl/reserv_station_if.sv
// Dispatch / common-data-bus / functional-unit bundle of the reservation station.
// The station uses the slave modport; the dispatch side uses master.
interface reserv_station_if
  import reserv_station_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = TAG_W_DEF
);

  localparam int CNT_W = $clog2(ENTRIES + 1);

  logic              issue_valid;
  logic              issue_ready;
  logic              issue_op;
  logic [DATA_W-1:0] issue_vj;
  logic [DATA_W-1:0] issue_vk;
  logic [TAG_W-1:0]  issue_qj;
  logic [TAG_W-1:0]  issue_qk;
  logic [TAG_W-1:0]  issue_tag;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              fu_valid;
  logic              fu_ready;
  logic              fu_op;
  logic [DATA_W-1:0] fu_a;
  logic [DATA_W-1:0] fu_b;
  logic [TAG_W-1:0]  fu_tag;

  logic [CNT_W-1:0]  count;

  modport master (
    output issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
    output cdb_valid, cdb_tag, cdb_data,
    output fu_ready,
    input  issue_ready, issue_tag,
    input  fu_valid, fu_op, fu_a, fu_b, fu_tag,
    input  count
  );

  modport slave (
    input  issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
    input  cdb_valid, cdb_tag, cdb_data,
    input  fu_ready,
    output issue_ready, issue_tag,
    output fu_valid, fu_op, fu_a, fu_b, fu_tag,
    output count
  );

endinterface : reserv_station_if

// File: rtl/reserv_station_prio_enc.sv
// Lowest-index priority encoder, shared by free-slot and ready-slot selection.
module rs_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one to win
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end else begin
        any = any;
      end
    end
  end

endmodule : rs_prio_enc

// File: rtl/reserv_station.sv
// Tomasulo-style reservation station with CDB operand snooping.
// Optional macro RS_BYPASS_EN: forward a same-cycle CDB broadcast into an issuing entry.
module reserv_station
  import reserv_station_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int RS_BASE = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             flush,
  reserv_station_if.slave  bus
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W = $clog2(ENTRIES + 1);
  localparam logic [TAG_W-1:0] TAG_Z = TAG_W'(TAG_NONE);

  logic [ENTRIES-1:0] busy_r;
  logic [ENTRIES-1:0] op_r;
  logic [DATA_W-1:0]  vj_r [ENTRIES];
  logic [DATA_W-1:0]  vk_r [ENTRIES];
  logic [TAG_W-1:0]   qj_r [ENTRIES];
  logic [TAG_W-1:0]   qk_r [ENTRIES];

  logic [ENTRIES-1:0] free_vec_s;
  logic [ENTRIES-1:0] ready_vec_s;
  logic               free_any_s;
  logic               ready_any_s;
  logic [IDX_W-1:0]   free_idx_s;
  logic [IDX_W-1:0]   ready_idx_s;

  logic               issue_fire_s;
  logic               dispatch_s;
  logic               cdb_live_s;
  logic [DATA_W-1:0]  iss_vj_s;
  logic [DATA_W-1:0]  iss_vk_s;
  logic [TAG_W-1:0]   iss_qj_s;
  logic [TAG_W-1:0]   iss_qk_s;

  // Slot status vectors feeding the two priority encoders
  always_comb begin
    free_vec_s  = '0;
    ready_vec_s = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      free_vec_s[i]  = ~busy_r[i];
      ready_vec_s[i] = busy_r[i] && (qj_r[i] == TAG_Z) && (qk_r[i] == TAG_Z);
    end
  end

  rs_prio_enc #(.N(ENTRIES), .IDX_W(IDX_W)) u_free_enc (
    .req (free_vec_s),
    .any (free_any_s),
    .idx (free_idx_s)
  );

  rs_prio_enc #(.N(ENTRIES), .IDX_W(IDX_W)) u_ready_enc (
    .req (ready_vec_s),
    .any (ready_any_s),
    .idx (ready_idx_s)
  );

  // Issue-side handshake and tag of the slot the offered instruction will take
  always_comb begin
`ifdef RS_BYPASS_EN
    bus.issue_ready = free_any_s && !flush;
`else
    // Without forwarding, a broadcast would slip past an issuing entry
    bus.issue_ready = free_any_s && !flush && !bus.cdb_valid;
`endif
    if (free_any_s) begin
      bus.issue_tag = TAG_W'(RS_BASE) + TAG_W'(free_idx_s);
    end else begin
      bus.issue_tag = TAG_Z;
    end
  end

  assign issue_fire_s = bus.issue_valid && bus.issue_ready;
  assign dispatch_s   = ready_any_s && bus.fu_ready;
  assign cdb_live_s   = bus.cdb_valid && (bus.cdb_tag != TAG_Z);

  // Operand values and tags written into the slot on issue
  always_comb begin
    iss_vj_s = bus.issue_vj;
    iss_vk_s = bus.issue_vk;
    iss_qj_s = bus.issue_qj;
    iss_qk_s = bus.issue_qk;
`ifdef RS_BYPASS_EN
    if (cdb_live_s && (bus.issue_qj == bus.cdb_tag)) begin
      iss_vj_s = bus.cdb_data;
      iss_qj_s = TAG_Z;
    end else begin
      iss_qj_s = bus.issue_qj;
    end
    if (cdb_live_s && (bus.issue_qk == bus.cdb_tag)) begin
      iss_vk_s = bus.cdb_data;
      iss_qk_s = TAG_Z;
    end else begin
      iss_qk_s = bus.issue_qk;
    end
`endif
  end

  // Functional-unit offer from the lowest-index ready slot, zeroed when idle
  always_comb begin
    bus.fu_valid = ready_any_s;
    if (ready_any_s) begin
      bus.fu_op  = op_r[ready_idx_s];
      bus.fu_a   = vj_r[ready_idx_s];
      bus.fu_b   = vk_r[ready_idx_s];
      bus.fu_tag = TAG_W'(RS_BASE) + TAG_W'(ready_idx_s);
    end else begin
      bus.fu_op  = OP_SUBDIV;
      bus.fu_a   = '0;
      bus.fu_b   = '0;
      bus.fu_tag = TAG_Z;
    end
  end

  // Occupancy count over the busy flags
  always_comb begin
    bus.count = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      bus.count = bus.count + CNT_W'(busy_r[i]);
    end
  end

  // Slot storage: reset, flush, then per-slot snoop / dispatch / issue
  always_ff @(posedge clock) begin
    if (!resetn) begin
      busy_r <= '0;
      op_r   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        vj_r[i] <= '0;
        vk_r[i] <= '0;
        qj_r[i] <= TAG_Z;
        qk_r[i] <= TAG_Z;
      end
    end else if (flush) begin
      busy_r <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        // Issue only targets a free slot; snoop and dispatch only touch busy ones
        if (issue_fire_s && (free_idx_s == IDX_W'(i))) begin
          busy_r[i] <= 1'b1;
          op_r[i]   <= bus.issue_op;
          vj_r[i]   <= iss_vj_s;
          vk_r[i]   <= iss_vk_s;
          qj_r[i]   <= iss_qj_s;
          qk_r[i]   <= iss_qk_s;
        end else if (busy_r[i]) begin
          if (dispatch_s && (ready_idx_s == IDX_W'(i))) begin
            busy_r[i] <= 1'b0;
          end
          if (cdb_live_s && (qj_r[i] == bus.cdb_tag)) begin
            vj_r[i] <= bus.cdb_data;
            qj_r[i] <= TAG_Z;
          end
          if (cdb_live_s && (qk_r[i] == bus.cdb_tag)) begin
            vk_r[i] <= bus.cdb_data;
            qk_r[i] <= TAG_Z;
          end
        end
      end
    end
  end

endmodule : reserv_station

// File: doc/reserv_station.md
RESERV_STATION -- requirements
Module: reserv_station

Interface
REQ-001 Parameter ENTRIES, default 4, number of station slots.
REQ-002 Parameter DATA_W, default 17, operand/result width.
REQ-003 Parameter TAG_W, default 3, producer-tag width; tag 0 means "value present".
REQ-004 Parameter RS_BASE, default 1, tag of slot 0; slot i owns tag RS_BASE+i; RS_BASE >= 1 and RS_BASE+ENTRIES-1 < 2**TAG_W.
REQ-005 clock  in  1  single clock, all state on rising edge.
REQ-006 resetn  in  1  reset, synchronous, active-low.
REQ-007 flush  in  1  synchronous clear of all slots.
REQ-008 issue_valid  in  1  dispatch queue offers an instruction.
REQ-009 issue_ready  out  1  station accepts an instruction this cycle.
REQ-010 issue_op  in  1  operation type, 1 = mul/add, 0 = div/sub.
REQ-011 issue_vj, issue_vk  in  DATA_W each  operand values from the register bank.
REQ-012 issue_qj, issue_qk  in  TAG_W each  producer tags; 0 = the matching value is valid.
REQ-013 issue_tag  out  TAG_W  tag of the slot the offered instruction will occupy.
REQ-014 cdb_valid  in  1  common data bus carries a result.
REQ-015 cdb_tag  in  TAG_W  producer tag of the result.
REQ-016 cdb_data  in  DATA_W  result value.
REQ-017 fu_valid  out  1  an operand pair is offered to the functional unit.
REQ-018 fu_ready  in  1  functional unit accepts.
REQ-019 fu_op, fu_a, fu_b, fu_tag  out  1/DATA_W/DATA_W/TAG_W  operation, operands, destination tag.
REQ-020 count  out  clog2(ENTRIES+1)  number of busy slots.

Function
REQ-021 Each slot holds busy, op, vj, vk, qj, qk; a slot is ready when busy, qj==0 and qk==0.
REQ-022 issue_ready SHALL be 1 when at least one slot is not busy and flush is 0, and is computed from current-cycle state only, so a slot freed by dispatch this cycle is reusable next cycle.
REQ-023 The issue handshake fires on issue_valid && issue_ready; the lowest-index free slot is written with busy=1, and issue_tag SHALL equal RS_BASE plus that index (0 when full).
REQ-024 fu_valid SHALL be 1 when any slot is ready; the lowest-index ready slot is selected and fu_op/fu_a/fu_b/fu_tag are driven from it combinationally; all are 0 when fu_valid is 0.
REQ-025 On fu_valid && fu_ready the selected slot clears busy at the next edge; with fu_ready low the same slot stays presented, outputs stable.
REQ-026 CDB snoop: for every busy slot with qj==cdb_tag!=0 while cdb_valid, vj<=cdb_data and qj<=0; likewise qk/vk, independently, so both operands may capture from one broadcast.
REQ-027 A slot that captures from the CDB becomes ready at the next edge; minimum issue-to-fu_valid latency is 1 cycle.
REQ-028 cdb_tag equal to 0 or matching no pending slot SHALL change no state.
REQ-029 Simultaneous issue and dispatch in one cycle are both honoured.
REQ-030 flush has priority over issue, dispatch and snoop: all busy cleared at the edge, and count becomes 0.

Reset
REQ-031 While resetn is 0 at a rising edge, all busy, qj and qk SHALL be cleared and vj/vk zeroed; outputs then read issue_ready=1, issue_tag=RS_BASE, fu_valid=0, fu_op=0, fu_a=0, fu_b=0, fu_tag=0, count=0.
REQ-032 Reset mid-operation discards all pending slots; no fu handshake completes in the reset cycle.

Configuration
REQ-033 Macro RS_BYPASS_EN defined: an issuing instruction whose issue_qj/issue_qk matches cdb_tag while cdb_valid is written with cdb_data and tag 0 for that operand.
REQ-034 Macro RS_BYPASS_EN undefined: issue_ready SHALL additionally be 0 whenever cdb_valid is 1, so no broadcast is missed.

Structure
REQ-035 A shared package holds the DATA_W/TAG_W defaults, the encoding TAG_NONE=0, and the op encodings OP_ADDMUL=1/OP_SUBDIV=0.
REQ-036 One sub-module, rs_prio_enc, is a lowest-index priority encoder reused for free-slot and ready-slot selection.

Verification
REQ-037 Issue op=1, vj=5, vk=7, qj=qk=0; fu_ready=1 -> fu_valid next cycle with fu_a=5, fu_b=7, fu_tag=1; count returns 1->0.
REQ-038 Issue qj=3, vk=9; hold off, then cdb_valid with tag 3, data 0x00AB -> fu_valid one cycle later with fu_a=0x00AB, fu_b=9.
REQ-039 Four issues with qj=7 and no CDB -> issue_ready=0 and count=4; a fifth issue_valid is ignored; broadcast tag 7 -> slots dispatch in order 1,2,3,4 with fu_ready held 1.
REQ-040 Issue qj=qk=5, then broadcast tag 5, data 0x1FFFF -> fu_a=fu_b=0x1FFFF.
REQ-041 Issue qj=2 in the same cycle as cdb tag 2, data 4 -> with RS_BYPASS_EN, fu_a=4 next cycle; without it, issue_ready=0 that cycle.
REQ-042 Three busy slots, then resetn=0 for one edge (repeat with flush=1) -> count=0, fu_valid=0, issue_tag=1 on the next cycle.
